// File: rtl/digit_scan_ctrl.sv
// Multiplexed scan controller for a 4-digit 7-segment display.
// Display data is double-buffered and takes effect only at the frame wrap.
module digit_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        blank,
  output logic        frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   stg_q, stg_d, shd_q, shd_d;
  logic [3:0]    stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic          pend_q, pend_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpn_q, dpn_d, blank_q, blank_d, frame_q, frame_d;
  logic          tick, wrap, dark;
  logic [3:0]    nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bcnt_q   <= BLANK_INIT;
      dig_q    <= 2'd0;
      stg_q    <= '0;
      stg_dp_q <= '0;
      shd_q    <= '0;
      shd_dp_q <= '0;
      pend_q   <= 1'b0;
      seg_q    <= 7'h7F;
      dpn_q    <= 1'b1;
      blank_q  <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      dig_q    <= dig_d;
      stg_q    <= stg_d;
      stg_dp_q <= stg_dp_d;
      shd_q    <= shd_d;
      shd_dp_q <= shd_dp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      dpn_q    <= dpn_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
    end
  end

  // Scan timing and buffer transfer
  always_comb begin
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    dig_d    = dig_q;
    stg_d    = stg_q;
    stg_dp_d = stg_dp_q;
    shd_d    = shd_q;
    shd_dp_d = shd_dp_q;
    pend_d   = pend_q;
    tick     = (cnt_q == CNT_MAX);
    wrap     = tick && (dig_q == 2'd3);
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        dig_d  = dig_q + 2'd1;
        bcnt_d = BLANK_INIT;
      end else if (bcnt_q != '0) begin
        bcnt_d = bcnt_q - 1'b1;
      end
    end
    if (load) begin
      stg_d    = digits_in;
      stg_dp_d = dp_in;
      if (en) pend_d = 1'b1;
    end
    // A load landing on the wrap bypasses staging so it shows this frame
    if (en && wrap) begin
      if (load) begin
        shd_d    = digits_in;
        shd_dp_d = dp_in;
      end else if (pend_q) begin
        shd_d    = stg_q;
        shd_dp_d = stg_dp_q;
      end
      pend_d = 1'b0;
    end
  end

  // Outputs are decoded from next state so they register alongside digit_sel
  always_comb begin
    nib  = shd_d[{dig_d, 2'b00} +: 4];
    dark = 1'b0;
    case (dig_d)
      2'd3:    dark = (shd_d[15:12] == 4'h0);
      2'd2:    dark = (shd_d[15:8] == 8'h00);
      2'd1:    dark = (shd_d[15:4] == 12'h000);
      default: dark = 1'b0;
    endcase
    dark    = dark && blank_lz;
    seg_d   = 7'h7F;
    dpn_d   = 1'b1;
    blank_d = 1'b1;
    frame_d = en && wrap;
    if (en && (bcnt_d == '0)) begin
      seg_d   = dark ? 7'h7F : seg7(nib);
      dpn_d   = ~shd_dp_d[dig_d];
      blank_d = 1'b0;
    end
  end

  assign digit_sel  = dig_q;
  assign seg_n      = seg_q;
  assign dp_n       = dpn_q;
  assign blank      = blank_q;
  assign frame_done = frame_q;

endmodule
